// File: rtl/sdp_ram_arbiter.sv
// Shares one simple-dual-port block RAM between two requesters.
// Write port and read port each run an independent round-robin arbiter; read data is routed back by a tag pipeline.
module sdp_ram_arbiter #(
  parameter int DATAW    = 32,
  parameter int ADDRW    = 32,
  parameter int WORD_LEN = 2,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,

  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [ADDRW-1:0] req0_addr,
  input  logic [DATAW-1:0] req0_wdata,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [DATAW-1:0] rsp0_rdata,

  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [ADDRW-1:0] req1_addr,
  input  logic [DATAW-1:0] req1_wdata,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [DATAW-1:0] rsp1_rdata,

  output logic             ram_wea,
  output logic [ADDRW-1:0] ram_addra,
  output logic [DATAW-1:0] ram_dina,
  output logic [ADDRW-1:0] ram_addrb,
  input  logic [DATAW-1:0] ram_doutb
);

  localparam logic [ADDRW-1:0] WORD_MASK = {ADDRW{1'b1}} << WORD_LEN;

  logic [1:0]       req_valid;
  logic [1:0]       req_we;
  logic [ADDRW-1:0] req_addr  [2];
  logic [DATAW-1:0] req_wdata [2];

  assign req_valid    = {req1_valid, req0_valid};
  assign req_we       = {req1_we, req0_we};
  assign req_addr[0]  = req0_addr;
  assign req_addr[1]  = req1_addr;
  assign req_wdata[0] = req0_wdata;
  assign req_wdata[1] = req1_wdata;

  // Arbitration state and read-tag pipeline.
  logic                wr_last;
  logic                rd_last;
  logic [ADDRW-1:0]    last_rd_addr;
  logic [READ_LAT-1:0] trk_valid;
  logic [READ_LAT-1:0] trk_id;

  logic [1:0]       wr_cand;
  logic [1:0]       rd_cand;
  logic [1:0]       rd_collide;
  logic             wr_gnt;
  logic             wr_win;
  logic             rd_gnt;
  logic             rd_win;
  logic [ADDRW-1:0] wr_word;
  logic [ADDRW-1:0] rd_word;
  logic             rsp_hit;

  // With both requesters competing, the one that did not win last time goes first.
  function automatic logic rr_pick(input logic [1:0] cand, input logic last);
    if (cand == 2'b11) return ~last;
    return cand[1];
  endfunction

  always_comb begin
    // NOTE: give every combinational output a value before any conditional
    // assignment; a path that leaves one unassigned infers a latch.
    rd_collide = '0;

    wr_cand = req_valid & req_we & {2{rstn}};
    wr_gnt  = |wr_cand;
    wr_win  = rr_pick(wr_cand, wr_last);
    wr_word = req_addr[wr_win] & WORD_MASK;

    // A read to the word being written this cycle waits, so it later sees the new data.
    for (int i = 0; i < 2; i++) begin
      if (wr_gnt && ((req_addr[i] & WORD_MASK) == wr_word)) rd_collide[i] = 1'b1;
    end

    rd_cand = req_valid & ~req_we & {2{rstn}} & ~rd_collide;
    rd_gnt  = |rd_cand;
    rd_win  = rr_pick(rd_cand, rd_last);
    rd_word = req_addr[rd_win] & WORD_MASK;
  end

  assign req0_ready = (wr_gnt && !wr_win) || (rd_gnt && !rd_win);
  assign req1_ready = (wr_gnt &&  wr_win) || (rd_gnt &&  rd_win);

  assign ram_wea   = wr_gnt;
  assign ram_addra = wr_gnt ? wr_word : '0;
  assign ram_dina  = wr_gnt ? req_wdata[wr_win] : '0;
  assign ram_addrb = !rstn ? '0 : (rd_gnt ? rd_word : last_rd_addr);

  // The oldest pipeline stage lines up with ram_doutb for the read issued READ_LAT edges ago.
  assign rsp_hit    = rstn & trk_valid[READ_LAT-1];
  assign rsp0_valid = rsp_hit & ~trk_id[READ_LAT-1];
  assign rsp1_valid = rsp_hit &  trk_id[READ_LAT-1];
  assign rsp0_rdata = rsp0_valid ? ram_doutb : '0;
  assign rsp1_rdata = rsp1_valid ? ram_doutb : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      wr_last      <= 1'b1;
      rd_last      <= 1'b1;
      last_rd_addr <= '0;
      trk_valid    <= '0;
    end else begin
      if (wr_gnt) wr_last <= wr_win;
      if (rd_gnt) begin
        rd_last      <= rd_win;
        last_rd_addr <= rd_word;
      end
      // NOTE: trk_id is deliberately not reset; it is only ever read
      // qualified by trk_valid, which is.
      trk_valid[0] <= rd_gnt;
      trk_id[0]    <= rd_win;
      for (int i = 1; i < READ_LAT; i++) begin
        trk_valid[i] <= trk_valid[i-1];
        trk_id[i]    <= trk_id[i-1];
      end
    end
  end

endmodule
